// File: rtl/sram_req_adapter.sv
`default_nettype none
// ============================================================================
// Module  : sram_req_adapter
// Brief   : Valid/ready request front end for a single-port SRAM with
//           1-cycle registered read, plus a credit-limited in-order response
//           FIFO with fall-through for read data.
// Rev     : 1.0  initial release
// ============================================================================
module sram_req_adapter #(
    parameter int  DEPTH      = 128,
    parameter int  DATA_WIDTH = 128,
    parameter int  BYTE_WIDTH = 8,
    parameter int  RSP_DEPTH  = 2,
    localparam int ADDR_WIDTH = $clog2(DEPTH),
    localparam int BE_WIDTH   = (DATA_WIDTH + BYTE_WIDTH - 1) / BYTE_WIDTH,
    localparam int CNT_WIDTH  = $clog2(RSP_DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [BE_WIDTH-1:0]   req_be_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,

    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,

    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [BE_WIDTH-1:0]   mem_be_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam int                   PTR_WIDTH = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam logic [PTR_WIDTH-1:0] PTR_LAST  = PTR_WIDTH'(RSP_DEPTH - 1);
    localparam logic [CNT_WIDTH:0]   CREDITS   = (CNT_WIDTH + 1)'(RSP_DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_FULL  = CNT_WIDTH'(RSP_DEPTH);

    logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic [CNT_WIDTH-1:0]  count;
    logic                  inflight;

    logic [CNT_WIDTH:0]    outstanding;
    logic                  fifo_empty;
    logic                  accept;
    logic                  push;
    logic                  pop;

    // A read holds a credit from acceptance until its data leaves the block,
    // so the FIFO always has room for whatever comes back from the SRAM.
    assign fifo_empty  = (count == CNT_ZERO);
    assign outstanding = {1'b0, count} + {{CNT_WIDTH{1'b0}}, inflight};
    assign req_ready_o = !rst_i && (outstanding < CREDITS);
    assign accept      = req_valid_i && req_ready_o;

    assign mem_req_o   = accept;
    assign mem_we_o    = req_we_i;
    assign mem_addr_o  = req_addr_i;
    assign mem_be_o    = req_be_i;
    assign mem_wdata_o = req_wdata_i;

    // With nothing buffered, fresh SRAM data bypasses the FIFO entirely.
    assign rsp_valid_o = !fifo_empty || inflight;
    assign rsp_rdata_o = fifo_empty ? mem_rdata_i : fifo_mem[rd_ptr];

    assign pop  = !fifo_empty && rsp_ready_i;
    assign push = inflight && !(fifo_empty && rsp_ready_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= accept && !req_we_i;
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_rdata_i;
        end
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push && !pop && (count == CNT_FULL)));

endmodule
`default_nettype wire

// File: tb/tb_sram_req_adapter.sv
`default_nettype none
// ============================================================================
// Module  : tb_sram_req_adapter
// Brief   : Self-checking bench for sram_req_adapter with an attached SRAM
//           model and a queue/array reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_sram_req_adapter;

    localparam int DEPTH = 64;
    localparam int DW    = 32;
    localparam int BW    = 8;
    localparam int RD    = 2;
    localparam int AW    = $clog2(DEPTH);
    localparam int BEW   = DW / BW;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic           req_we = 1'b0;
    logic [AW-1:0]  req_addr = '0;
    logic [BEW-1:0] req_be = '0;
    logic [DW-1:0]  req_wdata = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [DW-1:0]  rsp_rdata;
    logic           mem_req;
    logic           mem_we;
    logic [AW-1:0]  mem_addr;
    logic [BEW-1:0] mem_be;
    logic [DW-1:0]  mem_wdata;
    logic [DW-1:0]  mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] sram_mem [DEPTH];
    logic [DW-1:0] ref_mem  [DEPTH];
    logic [DW-1:0] exp_q [$];

    always #5 clk = ~clk;

    sram_req_adapter #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DW),
        .BYTE_WIDTH (BW),
        .RSP_DEPTH  (RD)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_be_i    (req_be),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_be_o    (mem_be),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    // Single-port SRAM: byte-masked write, registered 1-cycle read.
    always @(posedge clk) begin
        if (mem_req) begin
            if (mem_we) begin
                for (int b = 0; b < BEW; b++) begin
                    if (mem_be[b]) sram_mem[mem_addr][b*BW +: BW] <= mem_wdata[b*BW +: BW];
                end
            end else begin
                mem_rdata <= sram_mem[mem_addr];
            end
        end
    end

    task automatic step(input logic v, input logic we, input logic [AW-1:0] a,
                        input logic [BEW-1:0] be, input logic [DW-1:0] d, input logic rr);
        @(negedge clk);
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_be    = be;
        req_wdata = d;
        rsp_ready = rr;
        #1;
    endtask

    task automatic model_accept();
        if (req_valid && req_ready) begin
            if (req_we) begin
                for (int b = 0; b < BEW; b++) begin
                    if (req_be[b]) ref_mem[req_addr][b*BW +: BW] = req_wdata[b*BW +: BW];
                end
            end else begin
                exp_q.push_back(ref_mem[req_addr]);
            end
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BEW-1:0] be);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 8 && !done; i++) begin
            step(1'b1, 1'b1, a, be, d, 1'b1);
            done = req_ready;
            model_accept();
        end
        if (!done) begin
            n_tests++; n_fail++;
            $display("FAIL write_accept: write to %0d never accepted within 8 cycles", a);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", req_ready); end
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
        @(negedge clk);
        rst = 1'b0;
        req_valid = 1'b0;
        #1;
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b expected 1", req_ready); end
    endtask

    task automatic test_write_read();
        do_write(AW'(5), 32'h0000A5A5, '1);
        step(1'b1, 1'b0, AW'(5), '0, '0, 1'b1);
        n_tests++; if (req_ready !== 1'b1 || mem_req !== 1'b1) begin n_fail++; $display("FAIL wr_rd_accept: ready=%b mem_req=%b expected 1/1", req_ready, mem_req); end
        step(1'b0, 1'b0, '0, '0, '0, 1'b1);
        n_tests++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL wr_rd_latency: rsp_valid=%b expected 1", rsp_valid); end
        n_tests++; if (rsp_rdata !== 32'h0000A5A5) begin n_fail++; $display("FAIL wr_rd_data: got %h expected 0000a5a5", rsp_rdata); end
        step(1'b0, 1'b0, '0, '0, '0, 1'b1);
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_rd_no_push: rsp_valid=%b expected 0", rsp_valid); end
    endtask

    task automatic test_partial_write();
        do_write(AW'(9), 32'h00001234, '1);
        do_write(AW'(9), 32'h000000FF, 4'b0001);
        step(1'b1, 1'b0, AW'(9), '0, '0, 1'b1);
        step(1'b0, 1'b0, '0, '0, '0, 1'b1);
        n_tests++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h000012FF) begin
            n_fail++; $display("FAIL partial_write: valid=%b data=%h expected 1/000012ff", rsp_valid, rsp_rdata);
        end
    endtask

    task automatic test_backpressure();
        int accepted;
        int got;
        for (int i = 0; i < 4; i++) do_write(AW'(i), {16'hC0DE, 16'(i)}, '1);
        accepted = 0;
        for (int c = 0; c < 4; c++) begin
            step(1'b1, 1'b0, AW'(accepted), '0, '0, 1'b0);
            if (req_ready) accepted++;
        end
        n_tests++; if (accepted != RD) begin n_fail++; $display("FAIL bp_accepts: got %0d accepted expected %0d", accepted, RD); end
        n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low: got %b expected 0", req_ready); end
        got = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            step(accepted < 4, 1'b0, AW'(accepted), '0, '0, 1'b1);
            if (rsp_valid) begin
                n_tests++;
                if (rsp_rdata !== {16'hC0DE, 16'(got)}) begin
                    n_fail++; $display("FAIL bp_order: rsp %0d got %h expected %h", got, rsp_rdata, {16'hC0DE, 16'(got)});
                end
                got++;
            end
            if (req_valid && req_ready) accepted++;
        end
        n_tests++; if (got != 4) begin n_fail++; $display("FAIL bp_count: got %0d responses expected 4", got); end
        step(1'b0, 1'b0, '0, '0, '0, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] vals [16];
        int acc;
        int rsp;
        for (int i = 0; i < 16; i++) begin
            vals[i] = $urandom;
            do_write(AW'(16 + i), vals[i], '1);
        end
        acc = 0;
        rsp = 0;
        for (int c = 0; c < 17; c++) begin
            step(c < 16, 1'b0, AW'(16 + c), '0, '0, 1'b1);
            if (c < 16) begin
                n_tests++;
                if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: cycle %0d ready=%b expected 1", c, req_ready); end
                else acc++;
            end
            if (c > 0) begin
                n_tests++;
                if (rsp_valid !== 1'b1 || rsp_rdata !== vals[c-1]) begin
                    n_fail++; $display("FAIL b2b_rsp: cycle %0d valid=%b data=%h expected 1/%h", c, rsp_valid, rsp_rdata, vals[c-1]);
                end else rsp++;
            end
        end
        n_tests++; if (acc != 16 || rsp != 16) begin n_fail++; $display("FAIL b2b_count: accepts=%0d rsps=%0d expected 16/16", acc, rsp); end
        step(1'b0, 1'b0, '0, '0, '0, 1'b1);
    endtask

    task automatic test_random();
        int ops;
        int cycles;
        bit have_op;
        logic cur_we;
        logic [AW-1:0] cur_addr;
        logic [BEW-1:0] cur_be;
        logic [DW-1:0] cur_wdata;
        logic [DW-1:0] exp;
        for (int a = 0; a < DEPTH; a++) do_write(AW'(a), $urandom, '1);
        ops = 0;
        cycles = 0;
        have_op = 1'b0;
        cur_we = 1'b0; cur_addr = '0; cur_be = '0; cur_wdata = '0;
        while (ops < 1000 && cycles < 20000) begin
            if (!have_op) begin
                cur_we    = 1'($urandom_range(0, 1));
                cur_addr  = AW'($urandom_range(0, 7));
                cur_be    = BEW'($urandom_range(0, 15));
                cur_wdata = $urandom;
                have_op   = 1'b1;
            end
            step($urandom_range(0, 4) != 0, cur_we, cur_addr, cur_be, cur_wdata, 1'($urandom_range(0, 1)));
            cycles++;
            n_tests++; if (req_ready !== (exp_q.size() < RD)) begin
                n_fail++; $display("FAIL rnd_ready: cycle %0d got %b with %0d outstanding", cycles, req_ready, exp_q.size());
            end
            n_tests++; if (rsp_valid !== (exp_q.size() != 0)) begin
                n_fail++; $display("FAIL rnd_valid: cycle %0d got %b with %0d outstanding", cycles, rsp_valid, exp_q.size());
            end
            if (rsp_valid && rsp_ready && exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                n_tests++; if (rsp_rdata !== exp) begin n_fail++; $display("FAIL rnd_data: cycle %0d got %h expected %h", cycles, rsp_rdata, exp); end
            end
            if (req_valid && req_ready) begin
                model_accept();
                ops++;
                have_op = 1'b0;
            end
        end
        for (int c = 0; c < 10 && exp_q.size() != 0; c++) begin
            step(1'b0, 1'b0, '0, '0, '0, 1'b1);
            exp = exp_q.pop_front();
            n_tests++; if (rsp_valid !== 1'b1 || rsp_rdata !== exp) begin
                n_fail++; $display("FAIL rnd_drain_data: valid=%b data=%h expected 1/%h", rsp_valid, rsp_rdata, exp);
            end
        end
        n_tests++; if (ops != 1000) begin n_fail++; $display("FAIL rnd_ops: completed %0d ops expected 1000", ops); end
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rnd_drain: %0d responses missing", exp_q.size()); end
        step(1'b0, 1'b0, '0, '0, '0, 1'b1);
    endtask

    task automatic test_reset_midop();
        step(1'b1, 1'b0, AW'(0), '0, '0, 1'b0);
        step(1'b1, 1'b0, AW'(1), '0, '0, 1'b0);
        step(1'b0, 1'b0, '0, '0, '0, 1'b0);
        step(1'b1, 1'b0, AW'(2), '0, '0, 1'b0);
        n_tests++; if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
            n_fail++; $display("FAIL midrst_buffered: valid=%b ready=%b expected 1/0", rsp_valid, req_ready);
        end
        #2;
        rst = 1'b1;
        #1;
        n_tests++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++; $display("FAIL midrst_assert: valid=%b ready=%b mem_req=%b expected 0/0/0", rsp_valid, req_ready, mem_req);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        #1;
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_release_ready: got %b expected 1", req_ready); end
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 1'b0, '0, '0, '0, 1'b1);
            n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_stale: cycle %0d rsp_valid=%b expected 0", c, rsp_valid); end
        end
        step(1'b1, 1'b0, AW'(0), '0, '0, 1'b1);
        step(1'b0, 1'b0, '0, '0, '0, 1'b1);
        n_tests++; if (rsp_valid !== 1'b1 || rsp_rdata !== ref_mem[0]) begin
            n_fail++; $display("FAIL midrst_mem_kept: valid=%b data=%h expected 1/%h", rsp_valid, rsp_rdata, ref_mem[0]);
        end
    endtask

    initial begin
        for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
        test_reset();
        test_write_read();
        test_partial_write();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/sram_req_adapter.md
Name: sram_req_adapter

Overview:
- Valid/ready front end that drives the single-port `sram` macro: accepts read/write requests and issues them on the SRAM strobe interface.
- Captures read data one cycle after issue and returns it on an in-order valid/ready response stream.
- A credit-limited response FIFO absorbs downstream backpressure, so no read data is ever lost.
- Sits directly between an interconnect/requester and `sram`.

Parameters:
- Depth, 128, SRAM word count; must match the attached `sram`.
- DataWidth, 128, data word width in bits.
- ByteWidth, 8, byte-enable granule width in bits.
- RspDepth, 2, response FIFO entries; legal range >=1; full read throughput requires >=2.
- AddrWidth (local), $clog2(Depth), address width.
- ByteEnWidth (local), ceil(DataWidth/ByteWidth), byte-enable width.
- CntWidth (local), $clog2(RspDepth+1), credit counter width.

Ports:
- clk_i  in  1  clock; all state on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid&&ready.
- req_we_i  in  1  1=write, 0=read.
- req_addr_i  in  AddrWidth  word address.
- req_be_i  in  ByteEnWidth  byte enables (writes only).
- req_wdata_i  in  DataWidth  write data.
- rsp_valid_o  out  1  read data valid.
- rsp_ready_i  in  1  downstream accepts read data.
- rsp_rdata_o  out  DataWidth  read data.
- mem_req_o  out  1  to sram req_i.
- mem_we_o  out  1  to sram we_i.
- mem_addr_o  out  AddrWidth  to sram addr_i.
- mem_be_o  out  ByteEnWidth  to sram be_i.
- mem_wdata_o  out  DataWidth  to sram wdata_i.
- mem_rdata_i  in  DataWidth  from sram rdata_o1 (1-cycle registered read).

Behaviour:
- Reset: one clock (clk_i); reset rst_i is asynchronous and active-high.
  - All state clears: FIFO pointers and count = 0, in-flight flag = 0.
  - Outputs during reset: rsp_valid_o=0, req_ready_o=0, mem_req_o=0.
  - req_ready_o becomes 1 in the first cycle after reset deassertion.
- Issue path is combinational pass-through:
  - mem_req_o = req_valid_i && req_ready_o.
  - mem_we_o/addr/be/wdata = req_* unconditionally.
  - Request-to-SRAM latency is 0 cycles.
- Credits:
  - outstanding = fifo_count + inflight, where inflight is set when a read is accepted and cleared the next cycle.
  - req_ready_o = (outstanding < RspDepth), for both reads and writes.
  - req_ready_o does not depend on req_valid_i or req_we_i.
  - Writes consume no credit and produce no response.
- Read data, cycle N issue:
  - inflight=1 in N+1; mem_rdata_i is valid in N+1 only.
  - FIFO empty in N+1: rsp_valid_o=1 with rsp_rdata_o=mem_rdata_i (fall-through). If rsp_ready_i=1 the entry is consumed with no push; otherwise it is pushed.
  - FIFO non-empty: mem_rdata_i is pushed at the end of N+1; the response comes from the FIFO head.
  - Min read latency is 1 cycle; order is strictly preserved.
- Simultaneous push and pop on a non-empty FIFO: count is unchanged and pointers both advance, with wrap modulo RspDepth.
- FIFO can never overflow: the credit check guarantees room. An overflow is an assertion failure (simulation-only).
- Back-to-back: with RspDepth>=2 and rsp_ready_i=1, one read is accepted every cycle.
- With rsp_ready_i=0:
  - Exactly RspDepth reads are accepted, then req_ready_o=0.
  - Writes stall too, preserving read/write ordering relative to later reads.
- Read-after-write to the same address in consecutive cycles returns the new data (guaranteed by the SRAM write-then-read order).
- Reset mid-operation: the in-flight read and FIFO contents are discarded and no response is emitted. SRAM contents are untouched.
- rsp_rdata_o is don't-care when rsp_valid_o=0.

Test Plan:
- Reset, then write addr 5 data 0xA5A5 be all-ones; read addr 5 with rsp_ready_i=1 -> rsp_valid_o=1 exactly 1 cycle after accept, rsp_rdata_o=0xA5A5, no FIFO push.
- Partial write: be=0x1 data 0xFF over word 0x1234 (DataWidth=16) -> readback 0x12FF.
- rsp_ready_i=0, stream reads to addrs 0,1,2,3 (RspDepth=2) -> only 0,1 accepted, req_ready_o=0. Raise rsp_ready_i -> responses in order 0,1, then 2,3 accepted and returned in order.
- Continuous reads of 16 addresses with rsp_ready_i=1 -> 16 accepts in 16 consecutive cycles, 16 in-order responses, latency 1.
- Random rsp_ready_i toggling on 1000 mixed reads/writes versus a reference memory model -> every read matches, no drops, no duplicates, outstanding never exceeds RspDepth.
- Assert rst_i asynchronously mid-cycle with 2 responses buffered -> rsp_valid_o=0 and req_ready_o=0 immediately. After release, no stale response and req_ready_o=1.
